// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the fetch PC, issues one word read at a time to a
// variable-latency instruction memory and presents the result under valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  output logic [3:0]  cond,
  output logic [1:0]  op,
  output logic [5:0]  funct,
  output logic [3:0]  rd,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, WAIT, VALID, FAULT} state_t;

  localparam int          TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [15:0] TO_LAST   = TO_LAST_I[15:0];
  localparam bit          TO_EN     = (TIMEOUT != 0);

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] instr_n, pc_n;
  logic [15:0] wait_cnt, wait_cnt_n;
  logic        fetch_err_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      instr     <= 32'h0;
      pc        <= 32'h0;
      wait_cnt  <= 16'h0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      instr     <= instr_n;
      pc        <= pc_n;
      wait_cnt  <= wait_cnt_n;
      fetch_err <= fetch_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    instr_n     = instr;
    pc_n        = pc;
    wait_cnt_n  = wait_cnt;
    fetch_err_n = fetch_err;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IDLE: begin
        wait_cnt_n = 16'h0;
        state_n    = WAIT;
      end
      WAIT: begin
        imem_req = 1'b1;
        // A response arriving on the timeout cycle still counts as a successful fetch.
        if (imem_rvalid) begin
          instr_n    = imem_rdata;
          pc_n       = fetch_pc;
          wait_cnt_n = 16'h0;
          state_n    = VALID;
        end else if (TO_EN && (wait_cnt == TO_LAST)) begin
          fetch_err_n = 1'b1;
          state_n     = FAULT;
        end else begin
          wait_cnt_n = wait_cnt + 16'd1;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          fetch_pc_n = redirect ? (redirect_pc & 32'hFFFF_FFFC) : (pc + 32'd4);
          state_n    = WAIT;
        end
      end
      FAULT: begin
        fetch_err_n = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Decoder fields and architectural PC read value are pure views of the held instruction.
  assign imem_addr = fetch_pc;
  assign pc_plus8  = pc + 32'd8;
  assign cond      = instr[31:28];
  assign op        = instr[27:26];
  assign funct     = instr[25:20];
  assign rd        = instr[15:12];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, all checked every cycle
// against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          TO  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instr, pc, pc_plus8;
  logic [3:0]  cond, rd;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .pc(pc), .pc_plus8(pc_plus8),
    .cond(cond), .op(op), .funct(funct), .rd(rd),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0) return 32'hE280_0005;
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // Memory: mode 0 random latency 0..4, mode 1 fixed latency, mode 2 never answers.
  int mem_mode = 1;
  int lat_fix  = 0;
  int mem_cnt  = 0;
  int mem_lat  = 0;
  bit stray_force = 1'b0;
  bit stray_en    = 1'b0;

  always @(negedge clk) begin
    if (imem_req) begin
      if (mem_mode == 2) begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end else if (mem_cnt >= mem_lat) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data(imem_addr);
        mem_cnt     = 0;
      end else begin
        imem_rvalid = 1'b0;
        mem_cnt++;
      end
    end else begin
      mem_cnt     = 0;
      mem_lat     = (mem_mode == 1) ? lat_fix : int'($urandom_range(0, 4));
      imem_rvalid = stray_force || (stray_en && ($urandom_range(0, 3) == 0));
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // Reference model: what the fetch stream must look like after each clock edge.
  bit          m_idle = 1'b0, m_req = 1'b0, m_have = 1'b0, m_fault = 1'b0;
  logic [31:0] m_pc = RPC, m_instr = 32'h0, m_ipc = 32'h0;
  int          m_wait = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_idle = 1'b1; m_req = 1'b0; m_have = 1'b0; m_fault = 1'b0;
      m_pc = RPC; m_instr = 32'h0; m_ipc = 32'h0; m_wait = 0;
    end else if (m_idle) begin
      m_idle = 1'b0; m_req = 1'b1; m_wait = 0;
    end else if (m_req) begin
      if (imem_rvalid) begin
        m_instr = imem_rdata; m_ipc = m_pc; m_have = 1'b1; m_req = 1'b0; m_wait = 0;
      end else if (m_wait == TO - 1) begin
        m_fault = 1'b1; m_req = 1'b0;
      end else begin
        m_wait++;
      end
    end else if (m_have && instr_ready) begin
      m_pc   = redirect ? {redirect_pc[31:2], 2'b00} : m_ipc + 32'd4;
      m_have = 1'b0;
      m_req  = 1'b1;
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("imem_req", 32'(imem_req), 32'(m_req));
      if (m_req) chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(m_have));
      chk("instr", instr, m_instr);
      chk("pc", pc, m_ipc);
      chk("pc_plus8", pc_plus8, m_ipc + 32'd8);
      chk("cond", 32'(cond), 32'(m_instr[31:28]));
      chk("op", 32'(op), 32'(m_instr[27:26]));
      chk("funct", 32'(funct), 32'(m_instr[25:20]));
      chk("rd", 32'(rd), 32'(m_instr[15:12]));
      chk("fetch_err", 32'(fetch_err), 32'(m_fault));
    end
  end

  task automatic wait_req(input int maxc);
    for (int n = 0; n < maxc; n++) begin
      if (imem_req) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL wait_req timeout actual=0 expected=1 at %0t", $time);
  endtask

  task automatic wait_valid(input int maxc);
    for (int n = 0; n < maxc; n++) begin
      if (instr_valid) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL wait_valid timeout actual=0 expected=1 at %0t", $time);
  endtask

  task automatic handshake(input logic redir, input logic [31:0] target);
    instr_ready = 1'b1; redirect = redir; redirect_pc = target;
    @(negedge clk);
    instr_ready = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addrs[$];
    bit          prev_req;
    int          n;

    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    reset = 1'b0;

    // First fetch answered in the first WAIT cycle
    wait_req(5);
    chk("t1_addr", imem_addr, 32'h0);
    wait_valid(10);
    chk("t1_instr", instr, 32'hE280_0005);
    chk("t1_pc", pc, 32'h0);
    chk("t1_pc_plus8", pc_plus8, 32'h8);
    chk("t1_op", 32'(op), 32'h0);
    chk("t1_funct", 32'(funct), 32'h28);
    chk("t1_rd", 32'(rd), 32'h0);
    chk("t1_cond", 32'(cond), 32'hE);

    // Stall in VALID while redirect and stray responses toggle
    stray_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      redirect = ~redirect; redirect_pc = $urandom;
      @(negedge clk);
      chk("t3_hold_instr", instr, 32'hE280_0005);
      chk("t3_hold_pc", pc, 32'h0);
      chk("t3_hold_req", 32'(imem_req), 32'h0);
      chk("t3_hold_valid", 32'(instr_valid), 32'h1);
    end
    stray_force = 1'b0;
    handshake(1'b0, 32'h0);
    chk("t3_next_addr", imem_addr, 32'h4);

    // Redirect target has its low bits dropped
    wait_valid(10);
    handshake(1'b1, 32'h0000_0107);
    chk("t4_addr", imem_addr, 32'h0000_0104);
    wait_valid(10);
    chk("t4_pc", pc, 32'h0000_0104);

    // PC wraps from the top of the address space
    handshake(1'b1, 32'hFFFF_FFFF);
    chk("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid(10);
    chk("t6_top_pc", pc, 32'hFFFF_FFFC);
    chk("t6_top_pc_plus8", pc_plus8, 32'h0000_0004);
    handshake(1'b0, 32'h0);
    chk("t6_wrap_addr", imem_addr, 32'h0);

    // Back-to-back fetches with latency 3 and a consumer that is always ready
    lat_fix = 3;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    instr_ready = 1'b1;
    prev_req = 1'b0;
    for (int i = 0; i < 80 && addrs.size() < 4; i++) begin
      @(negedge clk);
      if (imem_req && !prev_req) addrs.push_back(imem_addr);
      prev_req = imem_req;
    end
    instr_ready = 1'b0;
    chk("t2_count", addrs.size(), 32'd4);
    for (int i = 0; i < addrs.size(); i++) chk("t2_seq", addrs[i], 32'(4 * i));

    // Timeout when memory never answers
    mem_mode = 2;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (fetch_err) break;
      if (imem_req) n++;
    end
    chk("t5_wait_cycles", 32'(n), 32'd16);
    chk("t5_err", 32'(fetch_err), 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_fault_req", 32'(imem_req), 32'h0);
      chk("t5_fault_err", 32'(fetch_err), 32'h1);
    end
    mem_mode = 1; lat_fix = 0;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_err_cleared", 32'(fetch_err), 32'h0);
    reset = 1'b0;
    wait_req(5);
    chk("t5_refetch_addr", imem_addr, RPC);
    wait_valid(10);

    // Reset mid-WAIT, then a stale response during IDLE
    mem_mode = 2;
    @(negedge clk);
    handshake(1'b0, 32'h0);
    repeat (2) @(negedge clk);
    chk("t6_midwait_req", 32'(imem_req), 32'h1);
    reset = 1'b1; stray_force = 1'b1; mem_mode = 1; lat_fix = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    stray_force = 1'b0;
    wait_valid(10);
    chk("t6_restart_pc", pc, RPC);
    chk("t6_restart_instr", instr, 32'hE280_0005);

    // Randomized traffic
    mem_mode = 0; stray_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      instr_ready = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 3) == 0);
      redirect_pc = $urandom;
      reset       = ($urandom_range(0, 199) == 0);
    end
    reset = 1'b0; instr_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
